// File: rtl/aes_chain_ctrl.sv
// Command sequencer for AES_Composite_enc: runs N chained encryptions per host command.
// Optional wait-timeout abort is enabled by defining AES_CHAIN_TIMEOUT_EN.
module aes_chain_ctrl #(
    parameter int unsigned ITER_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [127:0]      cmd_key,
    input  logic [127:0]      cmd_pt,
    input  logic [ITER_W-1:0] cmd_iter,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [127:0]      rsp_ct,
    output logic              rsp_err,
    output logic [127:0]      Kin,
    output logic [127:0]      Din,
    output logic              Krdy,
    output logic              Drdy,
    output logic              EN,
    input  logic              Kvld,
    input  logic              Dvld,
    input  logic [127:0]      Dout,
    input  logic              BSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_KWAIT,
        S_DATA,
        S_DWAIT,
        S_RESP
    } state_t;

    state_t            state;
    logic              key_loaded;
    logic [ITER_W-1:0] cnt;

    if (ITER_W == 0 || TIMEOUT == 0) begin : g_bad_param
        $error("aes_chain_ctrl: ITER_W and TIMEOUT must be at least 1");
    end

`ifdef AES_CHAIN_TIMEOUT_EN
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WAIT_W-1:0] wait_cnt;
`endif

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_ct     <= '0;
            rsp_err    <= 1'b0;
            Kin        <= '0;
            Din        <= '0;
            Krdy       <= 1'b0;
            Drdy       <= 1'b0;
            EN         <= 1'b0;
            key_loaded <= 1'b0;
            cnt        <= '0;
`ifdef AES_CHAIN_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        EN        <= 1'b1;
                        Din       <= cmd_pt;
                        cnt       <= (cmd_iter == '0) ? ITER_W'(1) : cmd_iter;
`ifdef AES_CHAIN_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        // An unchanged, already expanded key goes straight to data load
                        if (key_loaded && (cmd_key == Kin)) begin
                            state <= S_DATA;
                        end else begin
                            Kin        <= cmd_key;
                            key_loaded <= 1'b0;
                            Krdy       <= 1'b1;
                            state      <= S_KEY;
                        end
                    end
                end

                S_KEY: begin
                    Krdy  <= 1'b0;
                    state <= S_KWAIT;
                end

                S_KWAIT: begin
                    if (Kvld) begin
                        key_loaded <= 1'b1;
                        state      <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (!BSY) begin
                        Drdy  <= 1'b1;
                        state <= S_DWAIT;
                    end
                end

                S_DWAIT: begin
                    Drdy <= 1'b0;
                    if (Dvld) begin
                        // Feed each ciphertext back as the next plaintext
                        Din <= Dout;
                        cnt <= cnt - ITER_W'(1);
                        if (cnt == ITER_W'(1)) begin
                            rsp_ct    <= Dout;
                            rsp_valid <= 1'b1;
                            EN        <= 1'b0;
                            state     <= S_RESP;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

`ifdef AES_CHAIN_TIMEOUT_EN
            // Overrides the case above when the core fails to answer in time
            if ((state == S_KWAIT && !Kvld) || (state == S_DWAIT && !Dvld)) begin
                if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    rsp_err    <= 1'b1;
                    rsp_ct     <= '0;
                    rsp_valid  <= 1'b1;
                    key_loaded <= 1'b0;
                    EN         <= 1'b0;
                    state      <= S_RESP;
                end else begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            end else begin
                wait_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_aes_chain_ctrl.sv
// Self-checking bench for aes_chain_ctrl with a behavioural AES core model and response scoreboard.
// Define AES_CHAIN_TIMEOUT_EN to also exercise the wait-timeout abort (TIMEOUT=16).
module tb_aes_chain_ctrl;

    localparam int unsigned ITER_W  = 8;
    localparam int unsigned TIMEOUT = 16;
    localparam int KLAT = 4;
    localparam int DLAT = 6;
    localparam int BSY_TAIL = 2;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [127:0]      cmd_key;
    logic [127:0]      cmd_pt;
    logic [ITER_W-1:0] cmd_iter;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [127:0]      rsp_ct;
    logic              rsp_err;
    logic [127:0]      Kin;
    logic [127:0]      Din;
    logic              Krdy;
    logic              Drdy;
    logic              EN;
    logic              Kvld;
    logic              Dvld;
    logic [127:0]      Dout;
    logic              BSY;

    aes_chain_ctrl #(.ITER_W(ITER_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(clk), .RSTn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
        .cmd_pt(cmd_pt), .cmd_iter(cmd_iter),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ct(rsp_ct), .rsp_err(rsp_err),
        .Kin(Kin), .Din(Din), .Krdy(Krdy), .Drdy(Drdy), .EN(EN),
        .Kvld(Kvld), .Dvld(Dvld), .Dout(Dout), .BSY(BSY)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] ct;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                      ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[4*(((i/4) + (i%4)) % 4) + (i%4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rnd < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        return ct;
    endfunction

    function automatic logic [127:0] chain(input logic [127:0] key, input logic [127:0] pt, input int n);
        logic [127:0] d;
        d = pt;
        for (int i = 0; i < n; i++) d = aes_enc(key, d);
        return d;
    endfunction

    // ---------------- core model ----------------
    int           cyc;
    int           krdy_cnt;
    int           drdy_cnt;
    int           kvld_cyc;
    int           drdy_cyc;
    int           kdelay;
    int           ddelay;
    int           tail;
    logic         dvld_mute;
    logic [127:0] core_key;
    logic [127:0] core_din;
    logic [127:0] din_log [$];
    logic [127:0] dout_log [$];

    initial begin
        cyc = 0; krdy_cnt = 0; drdy_cnt = 0; kvld_cyc = 0; drdy_cyc = 0;
        kdelay = 0; ddelay = 0; tail = 0; dvld_mute = 1'b0;
        core_key = '0; core_din = '0;
        Kvld = 1'b0; Dvld = 1'b0; BSY = 1'b0; Dout = '0;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        Kvld <= 1'b0;
        Dvld <= 1'b0;
        if (!rst_n) begin
            kdelay = 0; ddelay = 0; tail = 0;
            BSY <= 1'b0;
        end else begin
            if (Krdy) begin
                core_key = Kin;
                kdelay   = KLAT;
                krdy_cnt = krdy_cnt + 1;
            end else if (kdelay > 0) begin
                kdelay = kdelay - 1;
                if (kdelay == 0) begin
                    Kvld <= 1'b1;
                    kvld_cyc = cyc;
                end
            end
            if (Drdy) begin
                core_din = Din;
                din_log.push_back(Din);
                ddelay   = DLAT;
                drdy_cnt = drdy_cnt + 1;
                drdy_cyc = cyc;
                BSY <= 1'b1;
            end else if (ddelay > 0) begin
                ddelay = ddelay - 1;
                if (ddelay == 0) begin
                    if (!dvld_mute) begin
                        Dout <= aes_enc(core_key, core_din);
                        dout_log.push_back(aes_enc(core_key, core_din));
                        Dvld <= 1'b1;
                    end
                    tail = BSY_TAIL;
                end
            end else if (tail > 0) begin
                tail = tail - 1;
                if (tail == 0) BSY <= 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    typedef struct packed {
        logic [127:0] ct;
        logic         err;
    } exp_t;

    exp_t sb [$];
    int   checks;
    int   errors;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [127:0] key, input logic [127:0] pt,
                            input logic [ITER_W-1:0] iter, input logic exp_krdy);
        exp_t e;
        for (int i = 0; i < 100 && !cmd_ready; i++) tick();
        chk("cmd_ready_wait", 128'(cmd_ready), 128'(1));
        cmd_valid = 1'b1;
        cmd_key   = key;
        cmd_pt    = pt;
        cmd_iter  = iter;
        tick();
        cmd_valid = 1'b0;
        e.ct  = chain(key, pt, (iter == '0) ? 1 : int'(iter));
        e.err = 1'b0;
        sb.push_back(e);
        chk("krdy_after_accept", 128'(Krdy), 128'(exp_krdy));
        chk("cmd_ready_busy", 128'(cmd_ready), 128'(0));
    endtask

    task automatic get_rsp(input int hold);
        exp_t e;
        for (int i = 0; i < 5000 && !rsp_valid; i++) tick();
        chk("rsp_valid_wait", 128'(rsp_valid), 128'(1));
        chk_int("sb_depth", sb.size(), 1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        chk("rsp_ct", rsp_ct, e.ct);
        chk("rsp_err", 128'(rsp_err), 128'(e.err));
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1;
            cmd_key   = ~e.ct;
            cmd_iter  = 8'd3;
            tick();
            chk("bp_valid", 128'(rsp_valid), 128'(1));
            chk("bp_ct", rsp_ct, e.ct);
            chk("bp_cmd_ready", 128'(cmd_ready), 128'(0));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_drop", 128'(rsp_valid), 128'(0));
        chk("idle_cmd_ready", 128'(cmd_ready), 128'(1));
        chk("idle_en", 128'(EN), 128'(0));
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2     = 128'h0123456789abcdef123456789abcdef0;
    localparam logic [127:0] KEY3     = 128'hdeadbeef00112233cafef00d44556677;

    initial begin
        int   k0;
        int   d0;
        logic seen;
        exp_t e;

        checks = 0; errors = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_key = '0; cmd_pt = '0; cmd_iter = '0; rsp_ready = 1'b0;
        build_sbox();

        // reset state
        tick(); tick(); tick();
        chk("rst_krdy", 128'(Krdy), 128'(0));
        chk("rst_drdy", 128'(Drdy), 128'(0));
        chk("rst_en", 128'(EN), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_err", 128'(rsp_err), 128'(0));
        chk("rst_kin", Kin, 128'(0));
        chk("rst_din", Din, 128'(0));
        chk("rst_rsp_ct", rsp_ct, 128'(0));
        rst_n = 1'b1;
        tick();
        chk("cmd_ready_after_rst", 128'(cmd_ready), 128'(1));

        // FIPS-197 single encryption
        k0 = krdy_cnt; d0 = drdy_cnt;
        send_cmd(FIPS_KEY, FIPS_PT, 8'd1, 1'b1);
        chk("fips_en", 128'(EN), 128'(1));
        get_rsp(0);
        chk("fips_vector", dout_log[dout_log.size()-1], FIPS_CT);
        chk_int("fips_krdy_pulses", krdy_cnt - k0, 1);
        chk_int("fips_drdy_pulses", drdy_cnt - d0, 1);
        chk_int("fips_drdy_after_kvld", int'(drdy_cyc > kvld_cyc), 1);

        // 10-deep chain under a new key
        k0 = krdy_cnt; d0 = drdy_cnt;
        din_log.delete(); dout_log.delete();
        send_cmd(KEY2, 128'h0, 8'd10, 1'b1);
        get_rsp(0);
        chk_int("chain_krdy_pulses", krdy_cnt - k0, 1);
        chk_int("chain_drdy_pulses", drdy_cnt - d0, 10);
        chk_int("chain_din_count", din_log.size(), 10);
        chk("chain_din0", din_log[0], 128'h0);
        for (int i = 1; i < 10 && i < din_log.size(); i++)
            chk($sformatf("chain_din%0d", i), din_log[i], dout_log[i-1]);

        // key reuse: no Krdy, Drdy within two cycles of accept
        k0 = krdy_cnt;
        send_cmd(KEY2, 128'hffeeddccbbaa99887766554433221100, 8'd1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (Drdy) seen = 1'b1;
        end
        chk("reuse_drdy_fast", 128'(seen), 128'(1));
        get_rsp(0);
        chk_int("reuse_no_krdy", krdy_cnt - k0, 0);

        // different key reloads
        k0 = krdy_cnt;
        send_cmd(KEY3, 128'h1, 8'd2, 1'b1);
        get_rsp(0);
        chk_int("newkey_krdy", krdy_cnt - k0, 1);

        // backpressure with iter=0 (behaves as 1), junk commands during RESP ignored
        d0 = drdy_cnt;
        send_cmd(KEY3, 128'h5a5a, 8'd0, 1'b0);
        get_rsp(20);
        chk_int("iter0_drdy", drdy_cnt - d0, 1);
        tick(); tick();
        chk("junk_ignored_en", 128'(EN), 128'(0));
        chk("junk_ignored_valid", 128'(rsp_valid), 128'(0));

        // reset during DWAIT of iteration 3
        d0 = drdy_cnt;
        send_cmd(KEY3, 128'h77, 8'd10, 1'b0);
        for (int i = 0; i < 2000 && drdy_cnt < d0 + 3; i++) tick();
        chk_int("mid_drdy_reached", drdy_cnt - d0, 3);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_krdy", 128'(Krdy), 128'(0));
        chk("mid_rst_drdy", 128'(Drdy), 128'(0));
        chk("mid_rst_en", 128'(EN), 128'(0));
        chk("mid_rst_rsp_valid", 128'(rsp_valid), 128'(0));
        if (sb.size() > 0) e = sb.pop_back();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        chk("mid_rst_no_rsp", 128'(seen), 128'(0));
        k0 = krdy_cnt;
        send_cmd(KEY3, 128'h99, 8'd2, 1'b1);
        get_rsp(0);
        chk_int("post_rst_krdy", krdy_cnt - k0, 1);

`ifdef AES_CHAIN_TIMEOUT_EN
        // core never answers: abort exactly TIMEOUT cycles after entering DWAIT
        dvld_mute = 1'b1;
        send_cmd(KEY3, 128'h1234, 8'd1, 1'b0);
        if (sb.size() > 0) e = sb.pop_back();
        e.ct  = '0;
        e.err = 1'b1;
        sb.push_back(e);
        for (int i = 0; i < 20 && !Drdy; i++) tick();
        chk("to_drdy_seen", 128'(Drdy), 128'(1));
        seen = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        chk("to_not_early", 128'(seen), 128'(0));
        tick();
        chk("to_valid_on_time", 128'(rsp_valid), 128'(1));
        get_rsp(0);
        dvld_mute = 1'b0;
        k0 = krdy_cnt;
        send_cmd(KEY3, 128'h4321, 8'd1, 1'b1);
        get_rsp(0);
        chk_int("to_key_reload", krdy_cnt - k0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_chain_ctrl.md
Name: aes_chain_ctrl

Overview:
- Upstream command sequencer for AES_Composite_enc. It turns a single host command (key, plaintext, iteration count) into the core's Krdy/Drdy/EN handshake sequence.
- It chains each ciphertext back as the next plaintext for N encryptions, then returns the final ciphertext on a valid/ready response port.
- It replaces hand-timed bench delays with handshake-driven sequencing, and skips key reload when the key is unchanged.

Parameters:
- ITER_W, 8, width of the iteration count field.
- TIMEOUT, 255, maximum cycles to wait for Kvld/Dvld; used only with AES_CHAIN_TIMEOUT_EN.

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RSTn  in  1  synchronous reset, active-low
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  controller can accept a command (high only in IDLE)
- cmd_key  in  128  AES key
- cmd_pt  in  128  initial plaintext
- cmd_iter  in  ITER_W  number of chained encryptions; 0 is treated as 1
- rsp_valid  out  1  final ciphertext available
- rsp_ready  in  1  host accepts response
- rsp_ct  out  128  final ciphertext
- rsp_err  out  1  timeout abort flag (constant 0 without the macro)
- Kin  out  128  key to core
- Din  out  128  data to core
- Krdy  out  1  key-load strobe, one cycle
- Drdy  out  1  data-load strobe, one cycle
- EN  out  1  core enable
- Kvld  in  1  core key-expansion done
- Dvld  in  1  core ciphertext valid
- Dout  in  128  core ciphertext
- BSY  in  1  core busy

Behaviour:
- Reset (RSTn=0 at a clock edge): state=IDLE. Krdy, Drdy, rsp_valid and rsp_err are 0. cmd_ready=1 after the first clock with RSTn=1. EN=0. Kin, Din and rsp_ct are 0. key_loaded=0. iteration counter=0.
- Reset mid-operation aborts immediately with no response. The core sees Krdy=Drdy=0 and EN=0 from the next cycle.
- EN=1 in every state except IDLE and RESP.
- IDLE: on cmd_valid&cmd_ready, latch Din<=cmd_pt and cnt<=max(cmd_iter,1).
  - If key_loaded=1 and cmd_key==Kin, go to DATA (key reuse).
  - Otherwise latch Kin<=cmd_key, clear key_loaded, and go to KEY.
- KEY: Krdy=1 for exactly one cycle, then KWAIT.
- KWAIT: wait for Kvld=1. Then set key_loaded=1 and go to DATA.
- DATA: if BSY=0, Drdy=1 for exactly one cycle and go to DWAIT. If BSY=1, hold with Drdy=0.
- DWAIT: on Dvld=1, Din<=Dout and cnt<=cnt-1.
  - If cnt==1, also rsp_ct<=Dout and go to RESP.
  - Otherwise go to DATA, so the next Drdy issues no earlier than one cycle after Dvld.
- RESP: rsp_valid=1 and rsp_ct stable until rsp_ready=1.
  - In the handshake cycle go to IDLE; cmd_ready=1 the following cycle.
  - rsp_valid must not drop without rsp_ready.
- cmd_valid while not in IDLE is ignored; cmd_ready=0 in all other states.
- Kvld/Dvld pulses arriving in a state not waiting for them are ignored.
- Kvld and Dvld in the same cycle: only the one the current state waits for is used.
- cnt is ITER_W wide. cmd_iter=2^ITER_W-1 runs the full count with no wrap.
- Minimum command-to-Krdy latency: 1 cycle (accept at edge T, Krdy high during cycle T+1).

Optional Feature:
- Macro AES_CHAIN_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to KWAIT or DWAIT and increments each cycle waiting there.
  - When it reaches TIMEOUT, the controller sets rsp_err=1, clears key_loaded, sets rsp_ct=0 and goes to RESP.
  - rsp_err is cleared on the next command accept.
- Not defined: no counter logic; KWAIT/DWAIT wait indefinitely; rsp_err tied to 0.

Test Plan:
- FIPS-197 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, iter=1 -> one Krdy pulse, one Drdy pulse after Kvld, rsp_ct=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0.
- Chain: key 0123456789abcdef123456789abcdef0, pt 0, iter=10 -> exactly 1 Krdy and 10 Drdy pulses; each Din equals the previous Dout; rsp_ct equals a reference model encrypting 0 ten times.
- Key reuse: a second command with the same key and iter=1 -> no Krdy pulse, Drdy within 2 cycles of accept. A third command with a different key -> Krdy pulse again.
- Backpressure: hold rsp_ready=0 for 20 cycles -> rsp_valid stays 1, rsp_ct stable, cmd_ready=0. Assert rsp_ready -> IDLE next cycle. iter=0 behaves as iter=1.
- Reset mid-run: drop RSTn during DWAIT of iteration 3 -> next cycle Krdy=Drdy=EN=rsp_valid=0. A new command after reset reloads the key (Krdy pulses).
- With AES_CHAIN_TIMEOUT_EN and TIMEOUT=16: a core model that never raises Dvld -> rsp_valid=1, rsp_err=1, rsp_ct=0 exactly 16 cycles after entering DWAIT.
